// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus widths, register word offsets,
// CTRL bit positions and the transfer state encoding.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = APB_DW / 8;

  // Word offsets, decoded from PADDR[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_VALUE  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  function automatic logic [APB_DW-1:0] strb_merge(
    input logic [APB_DW-1:0] cur,
    input logic [APB_DW-1:0] upd,
    input logic [APB_SW-1:0] strb
  );
    logic [APB_DW-1:0] r;
    r = cur;
    for (int i = 0; i < APB_SW; i++) begin
      if (strb[i]) r[8*i +: 8] = upd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_slave_if.sv
// APB completer front end: transfer FSM, wait-state counter,
// latched request and completion strobe.
module apb_slave_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic                  ready,
  output logic                  done,
  output logic                  wr,
  output logic [1:0]            idx,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] strb
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  apb_state_e state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       setup;
  logic       unused_addr;

  assign unused_addr = ^{paddr[ADDR_WIDTH-1:4], paddr[1:0]};

  assign setup = (state == IDLE) && psel && !penable;
  assign ready = (state == ACCESS) && (cnt == 3'd0);
  assign done  = ready && psel && penable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= 1'b0;
      idx   <= 2'd0;
      wdata <= '0;
      strb  <= '0;
    end else if (setup) begin
      wr    <= pwrite;
      idx   <= paddr[3:2];
      wdata <= pwdata;
      strb  <= pstrb;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = WAIT_INIT;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (penable && ready) begin
          state_nxt = IDLE;
        end else if (penable) begin
          cnt_nxt = cnt - 3'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer slave: 32-bit down counter with auto-reload,
// sticky expiry flag and registered interrupt.
module apb_timer_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_AW,
  parameter int DATA_WIDTH  = APB_DW,
  parameter int STRB_WIDTH  = APB_SW,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  irq_o
);

  logic                  ready, done, wr;
  logic [1:0]            idx;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] strb;

  apb_slave_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .WAIT_STATES(WAIT_STATES)
  ) u_if (
    .clk    (PCLK),
    .rst    (PRESET),
    .psel   (PSEL),
    .penable(PENABLE),
    .pwrite (PWRITE),
    .paddr  (PADDR),
    .pwdata (PWDATA),
    .pstrb  (PSTRB),
    .ready  (ready),
    .done   (done),
    .wr     (wr),
    .idx    (idx),
    .wdata  (wdata),
    .strb   (strb)
  );

  logic                  en, ar, ie, expired;
  logic [DATA_WIDTH-1:0] load, value;
  logic [DATA_WIDTH-1:0] ctrl_word, ctrl_new, load_new, rdata;
  logic                  wr_ctrl, wr_load, wr_stat, fire;
  logic                  unused_ctrl;

  assign ctrl_word = {{(DATA_WIDTH-3){1'b0}}, ie, ar, en};
  assign ctrl_new  = strb_merge(ctrl_word, wdata, strb);
  assign load_new  = strb_merge(load, wdata, strb);

  assign unused_ctrl = ^ctrl_new[DATA_WIDTH-1:3];

  assign wr_ctrl = done && wr && (idx == REG_CTRL);
  assign wr_load = done && wr && (idx == REG_LOAD);
  assign wr_stat = done && wr && (idx == REG_STATUS);
  assign fire    = en && (value == '0);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en      <= 1'b0;
      ar      <= 1'b0;
      ie      <= 1'b0;
      load    <= '0;
      value   <= '0;
      expired <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      irq_o <= expired & ie;

      // A CTRL write overrides the one-shot auto-disable
      if (wr_ctrl) begin
        en <= ctrl_new[CTRL_EN];
        ar <= ctrl_new[CTRL_AR];
        ie <= ctrl_new[CTRL_IE];
      end else if (fire && !ar) begin
        en <= 1'b0;
      end

      if (wr_load) load <= load_new;

      if (fire) begin
        expired <= 1'b1;
      end else if (wr_stat && strb[0] && wdata[0]) begin
        expired <= 1'b0;
      end

      if (wr_ctrl && !en && ctrl_new[CTRL_EN]) begin
        value <= load;
      end else if (wr_load && !en) begin
        value <= load_new;
      end else if (fire) begin
        value <= ar ? load : '0;
      end else if (en) begin
        value <= value - 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_CTRL:   rdata = ctrl_word;
      REG_LOAD:   rdata = load;
      REG_VALUE:  rdata = value;
      REG_STATUS: rdata = {{(DATA_WIDTH-1){1'b0}}, expired};
    endcase
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && wr && (idx == REG_VALUE);
  assign PRDATA  = (ready && !wr) ? rdata : '0;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: directed APB transfers checked every cycle
// against a register-level timer model plus literal read/irq values.
module tb_apb_timer_slave;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA, PRDATA0;
  logic        PREADY, PREADY0, PSLVERR, PSLVERR0, irq, irq0;

  always #5 clk = ~clk;

  apb_timer_slave #(.WAIT_STATES(WS)) dut (
    .PCLK(clk), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_o(irq)
  );

  apb_timer_slave #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA0), .PREADY(PREADY0), .PSLVERR(PSLVERR0), .irq_o(irq0)
  );

  typedef struct packed {
    logic        en;
    logic        ar;
    logic        ie;
    logic [31:0] load;
    logic [31:0] value;
    logic        expired;
    logic        irq;
  } mst_t;

  mst_t m;

  logic        started = 0;
  logic        exp_rdy = 0, exp_rdy0 = 0, exp_rd = 0, exp_err = 0;
  logic [1:0]  exp_a = '0;
  logic        lit_on = 0, lit_irq_on = 0, lit_irq = 0;
  logic [31:0] lit_val = '0;
  logic        pend_w = 0;
  logic [1:0]  pend_a = '0;
  logic [31:0] pend_d = '0;
  logic [3:0]  pend_s = '0;
  int          n_vec = 0, n_err = 0;

  function automatic logic [31:0] lanes(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] mk;
    mk = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mk) | (n & mk);
  endfunction

  function automatic mst_t step(mst_t s, logic w, logic [1:0] a, logic [31:0] d, logic [3:0] st);
    mst_t        n;
    logic        hit0;
    logic [31:0] c;
    n    = s;
    hit0 = s.en && (s.value == 32'd0);
    n.irq = s.expired && s.ie;
    if (s.en) begin
      if (hit0) begin
        n.expired = 1'b1;
        n.value   = s.ar ? s.load : 32'd0;
        if (!s.ar) n.en = 1'b0;
      end else begin
        n.value = s.value - 32'd1;
      end
    end
    if (w) begin
      if (a == 2'd0) begin
        c = lanes({29'd0, s.ie, s.ar, s.en}, d, st);
        n.en = c[0];
        n.ar = c[1];
        n.ie = c[2];
        if (!s.en && c[0]) n.value = s.load;
      end else if (a == 2'd1) begin
        n.load = lanes(s.load, d, st);
        if (!s.en) n.value = n.load;
      end else if (a == 2'd3) begin
        if (st[0] && d[0] && !hit0) n.expired = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] mread(mst_t s, logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, s.ie, s.ar, s.en};
      2'd1:    return s.load;
      2'd2:    return s.value;
      default: return {31'd0, s.expired};
    endcase
  endfunction

  always @(posedge clk) begin
    if (PRESET) m <= '0;
    else m <= step(m, pend_w, pend_a, pend_d, pend_s);
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        chk("pready", PREADY, exp_rdy);
        chk("pready_ws0", PREADY0, exp_rdy0);
        chk("pslverr", PSLVERR, exp_rdy && exp_err);
        if (!exp_rdy0) chk("prdata_ws0_idle", PRDATA0, 32'd0);
        if (!exp_rdy) begin
          chk("prdata_idle", PRDATA, 32'd0);
        end else if (exp_rd) begin
          chk("prdata_model", PRDATA, mread(m, exp_a));
          if (lit_on) chk("prdata_lit", PRDATA, lit_val);
        end
        chk("irq_model", irq, m.irq);
        if (lit_irq_on) chk("irq_lit", irq, lit_irq);
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int drop,
                      input logic has_lit, input logic [31:0] lv);
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s;
    @(negedge clk);
    PENABLE = 1;
    for (int i = 0; i <= WS; i++) begin
      exp_rdy0 = (i == 0);
      if (i == drop) begin
        PSEL = 0; PENABLE = 0;
        @(negedge clk);
        break;
      end
      if (i == WS) begin
        exp_rdy = 1; exp_rd = !w; exp_a = a[3:2];
        exp_err = w && (a[3:2] == 2'd2);
        lit_on = has_lit; lit_val = lv;
        pend_w = w; pend_a = a[3:2]; pend_d = d; pend_s = s;
      end
      @(negedge clk);
    end
    PSEL = 0; PENABLE = 0;
    exp_rdy = 0; exp_rdy0 = 0; exp_rd = 0; exp_err = 0;
    lit_on = 0; pend_w = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 4'hF, -1, 1'b0, 32'd0);
  endtask

  task automatic rdx(input logic [31:0] a, input logic [31:0] v);
    xfer(1'b0, a, 32'hDEAD_BEEF, 4'h0, -1, 1'b1, v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_irq(input logic v);
    lit_irq_on = 1; lit_irq = v;
    @(negedge clk);
    lit_irq_on = 0;
  endtask

  task automatic xfer_rst;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h4;
    PWDATA = 32'h99; PSTRB = 4'hF;
    @(negedge clk);
    PENABLE = 1; exp_rdy0 = 1;
    @(negedge clk);
    exp_rdy0 = 0; PRESET = 1;
    @(negedge clk);
    PSEL = 0; PENABLE = 0;
    @(negedge clk);
    PRESET = 0;
  endtask

  initial begin
    PRESET = 1;
    idle(2);
    PRESET = 0;
    started = 1;

    chk_irq(1'b0);
    rdx(32'h0, 32'h0);
    rdx(32'h4, 32'h0);
    rdx(32'h8, 32'h0);
    rdx(32'hC, 32'h0);

    wr(32'h4, 32'h0000_0010);
    rdx(32'h4, 32'h10);
    rdx(32'h8, 32'h10);

    wr(32'h4, 32'hAABB_CCDD);
    xfer(1'b1, 32'h4, 32'h1122_3344, 4'b0101, -1, 1'b0, 32'd0);
    rdx(32'h4, 32'hAA22_CC44);

    wr(32'h4, 32'd5);
    wr(32'h0, 32'h5);
    rdx(32'h8, 32'd1);
    rdx(32'hC, 32'd1);
    rdx(32'h0, 32'h4);
    chk_irq(1'b1);
    wr(32'hC, 32'h1);
    chk_irq(1'b1);
    chk_irq(1'b0);

    wr(32'h4, 32'd3);
    wr(32'h0, 32'h3);
    rdx(32'h8, 32'd3);
    wr(32'h0, 32'h0);
    wr(32'h4, 32'd12);
    wr(32'h0, 32'h3);
    idle(8);
    wr(32'hC, 32'h1);
    rdx(32'hC, 32'd1);

    wr(32'h0, 32'h0);
    wr(32'h4, 32'h0);
    wr(32'h0, 32'h7);
    wr(32'hC, 32'h1);
    rdx(32'hC, 32'd1);
    rdx(32'h8, 32'd0);
    chk_irq(1'b1);

    wr(32'h0, 32'h0);
    wr(32'h4, 32'h77);
    wr(32'h8, 32'h1234);
    rdx(32'h8, 32'h77);
    xfer(1'b1, 32'h4, 32'h55, 4'hF, 1, 1'b0, 32'd0);
    rdx(32'h7, 32'h77);
    rdx(32'h100_0004, 32'h77);

    wr(32'h0, 32'h7);
    idle(2);
    xfer_rst();
    idle(3);
    chk_irq(1'b0);
    rdx(32'h0, 32'h0);
    rdx(32'h4, 32'h0);
    rdx(32'h8, 32'h0);
    rdx(32'hC, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB completer (responder) holding a 32-bit down-counting timer with auto-reload and interrupt. It sits on one slave-select line of the APB master, alongside the GPIO and UART slaves. It answers every transfer the master initiates with a programmable number of wait states, strobed writes and error signalling.

## Interface
- `ADDR_WIDTH`, 32: PADDR width; only bits [3:2] are decoded, bits [1:0] are ignored.
- `DATA_WIDTH`, 32: PWDATA/PRDATA width; fixed at 32.
- `STRB_WIDTH`, 4: PSTRB width, one bit per byte.
- `WAIT_STATES`, 1: ACCESS cycles with PREADY low before completion. Legal range is 0–7.

Ports:
- `PCLK` in 1: single clock.
- `PRESET` in 1: synchronous, active-high reset.
- `PSEL` in 1: slave select from the APB master.
- `PENABLE` in 1: ACCESS-phase indicator.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in ADDR_WIDTH: byte address.
- `PWDATA` in DATA_WIDTH: write data.
- `PSTRB` in STRB_WIDTH: byte write strobes.
- `PRDATA` out DATA_WIDTH: read data; valid only while PREADY=1, otherwise 0.
- `PREADY` out 1: transfer completion.
- `PSLVERR` out 1: error response; valid only while PREADY=1.
- `irq_o` out 1: interrupt, registered; `irq_o` = STATUS.expired & CTRL.irq_en.

## Operation
Register map (PADDR[3:2]):
- 0x0 CTRL (RW): bit0 = `en`, bit1 = `auto_reload`, bit2 = `irq_en`; other bits read 0.
- 0x4 LOAD (RW, 32 bits).
- 0x8 VALUE (RO): current count.
- 0xC STATUS: bit0 = `expired`, write-1-to-clear.

Byte lanes and errors:
- Writes update only the byte lanes whose PSTRB bit is set.
- PSTRB is ignored on reads.
- A write to VALUE completes with PSLVERR=1 and has no side effect.
- All four addresses are mapped. PSLVERR is otherwise 0.

Transfer FSM:
- IDLE → ACCESS when PSEL=1 & PENABLE=0 (SETUP phase). On that edge the wait counter is loaded with WAIT_STATES, and PADDR, PWRITE, PWDATA and PSTRB are latched.
- ACCESS: PREADY = (wait counter == 0). While PENABLE=1 and the counter is nonzero, it decrements each cycle.
- Completion happens on the edge where PSEL & PENABLE & PREADY. The write commits, or PRDATA is presented in that cycle, then the FSM returns to IDLE.
- PSEL dropping before completion: return to IDLE. No register side effect.

Timer:
- With `en`=1, VALUE decrements by 1 every PCLK.
- When VALUE==0 and `en`=1: `expired` is set.
  - If `auto_reload`=1, VALUE ← LOAD.
  - Otherwise `en` ← 0 and VALUE holds 0.
- A write that takes `en` from 0→1 loads VALUE ← LOAD (new LOAD if written in the same transfer).
- A write to LOAD while `en`=0 also copies the value into VALUE.
- LOAD=0 with auto-reload: `expired` is set on every cycle.

Simultaneous events:
- STATUS W1C and expiry in the same cycle: expiry wins and `expired` stays 1.
- CTRL write and expiry in the same cycle: the CTRL write takes priority for `en`.

## Timing
- Reset values (next edge with PRESET=1): CTRL=0, LOAD=0, VALUE=0, STATUS=0, FSM=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, irq_o=0.
- Reset mid-transfer aborts the transfer with no side effect; the master sees PREADY=0.
- Transfer length is 2 + WAIT_STATES cycles, SETUP through completion. With WAIT_STATES=0, PREADY=1 in the first ACCESS cycle.
- PREADY, PSLVERR and PRDATA are driven combinationally from FSM state and registers. They return to 0 the cycle after completion.
- Read data reflects register contents in the completion cycle. VALUE read returns the pre-decrement value of that cycle.
- Register writes are visible from the cycle after completion.
- `irq_o` rises 1 cycle after `expired` is set. It falls 1 cycle after the W1C write commits.
- Back-to-back transfers are supported: the next SETUP may occur in the cycle after completion.

## Structure
- A shared package `apb_pkg` holds:
  - register offsets (CTRL/LOAD/VALUE/STATUS);
  - CTRL bit indices;
  - the FSM state enum (IDLE, ACCESS);
  - APB width constants. The GPIO and UART slaves reuse the offsets/width constants.
- One sub-module is natural: `apb_slave_if`. It holds the transfer FSM, wait counter, latched address/data and completion strobe, and is reusable by the other slaves.
- The timer datapath and register bank live in the top module.

## Test plan
- Reset: assert PRESET for 2 cycles mid-transfer → all outputs 0 and all registers read 0 afterwards; PREADY stays 0 until the next SETUP.
- Wait states: WAIT_STATES=3, write LOAD=0x0000_0010 → PREADY low for 3 ACCESS cycles and high on the 4th; read back 0x10.
- Strobes: LOAD=0xAABBCCDD, then write 0x11223344 with PSTRB=4'b0101 → read 0xAA22CC44.
- One-shot: LOAD=5, CTRL=0x5 → VALUE counts 5..0. Then `expired`=1, `en`=0 and `irq_o`=1 one cycle later. W1C STATUS=1 → `irq_o`=0.
- Auto-reload: LOAD=3, CTRL=0x3 → `expired` set every 4 cycles. A W1C issued on the expiry cycle leaves `expired`=1.
- Error: write to 0x8 → PSLVERR=1 in the completion cycle and VALUE unchanged. Dropping PSEL during the wait phase → no write committed.
